// File: rtl/cflog_writer_if.sv
// Event, flush-handshake and log-memory signals shared by the CF-Log writer and its environment.
// The writer uses the slave modport; the event source / log side uses master.
interface cflog_writer_if #(
  parameter int ADDR_MSB = 7
);
  logic              enable;
  logic              cf_valid;
  logic [15:0]       cf_src;
  logic [15:0]       cf_dst;
  logic              cf_ready;
  logic              flush_now;
  logic              flush_ack;
  logic              flush_req;
  logic              log_wen;
  logic [ADDR_MSB:0] log_addr;
  logic [15:0]       log_din1;
  logic [15:0]       log_din2;
  logic [ADDR_MSB:0] log_ptr;

  modport master (
    output enable, cf_valid, cf_src, cf_dst, flush_now, flush_ack,
    input  cf_ready, flush_req, log_wen, log_addr, log_din1, log_din2, log_ptr
  );

  modport slave (
    input  enable, cf_valid, cf_src, cf_dst, flush_now, flush_ack,
    output cf_ready, flush_req, log_wen, log_addr, log_din1, log_din2, log_ptr
  );
endinterface

// File: rtl/cflog_writer.sv
// CF-Log writer: logs src/dst pairs as two-word entries, folds identical consecutive pairs
// into a {FFFF, count} entry, and requests a flush when the log cannot take the next entry.
module cflog_writer #(
  parameter int LOG_SIZE = 256,
  parameter int ADDR_MSB = 7
) (
  input  logic          mclk,
  input  logic          puc_rst,
  cflog_writer_if.slave bus
);
  localparam int                WORDS   = LOG_SIZE / 2;
  localparam logic [ADDR_MSB:0] WORDS_W = (ADDR_MSB + 1)'(WORDS);
  localparam logic [ADDR_MSB:0] TWO     = (ADDR_MSB + 1)'(2);

  typedef enum logic [1:0] {IDLE, WR_CNT, WR_PAIR, FLUSH} state_t;

  state_t            state_q;
  logic [15:0]       rptCnt_q;
  logic              lastValid_q;
  logic [15:0]       lastSrc_q;
  logic [15:0]       lastDst_q;
  logic              pendValid_q;
  logic [15:0]       pendSrc_q;
  logic [15:0]       pendDst_q;
  logic              cfReady_q;
  logic              flushReq_q;
  logic              logWen_q;
  logic [ADDR_MSB:0] logAddr_q;
  logic [15:0]       logDin1_q;
  logic [15:0]       logDin2_q;
  logic [ADDR_MSB:0] logPtr_q;

  logic [ADDR_MSB:0] freeWords;
  logic              accept;
  logic              isRepeat;
  logic              cntPending;
  logic              fitsEntry;

  assign freeWords  = WORDS_W - logPtr_q;
  assign accept     = (state_q == IDLE) && bus.cf_valid;
  assign isRepeat   = lastValid_q && (bus.cf_src == lastSrc_q) && (bus.cf_dst == lastDst_q)
                      && (rptCnt_q != 16'hFFFF);
  assign cntPending = (rptCnt_q != 16'h0000);
  // Pointer and free space are always even, so one free entry is all a single write needs.
  assign fitsEntry  = (freeWords >= TWO);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q     <= IDLE;
      rptCnt_q    <= '0;
      lastValid_q <= 1'b0;
      lastSrc_q   <= '0;
      lastDst_q   <= '0;
      pendValid_q <= 1'b0;
      pendSrc_q   <= '0;
      pendDst_q   <= '0;
      cfReady_q   <= 1'b1;
      flushReq_q  <= 1'b0;
      logWen_q    <= 1'b0;
      logAddr_q   <= '0;
      logDin1_q   <= '0;
      logDin2_q   <= '0;
      logPtr_q    <= '0;
    end else begin
      logWen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (bus.enable && isRepeat) begin
              rptCnt_q <= rptCnt_q + 16'd1;
            end else if (bus.enable) begin
              cfReady_q <= 1'b0;
              pendSrc_q <= bus.cf_src;
              pendDst_q <= bus.cf_dst;
              if (fitsEntry && cntPending) begin
                logWen_q    <= 1'b1;
                logAddr_q   <= logPtr_q;
                logDin1_q   <= 16'hFFFF;
                logDin2_q   <= rptCnt_q;
                logPtr_q    <= logPtr_q + TWO;
                rptCnt_q    <= '0;
                pendValid_q <= 1'b1;
                state_q     <= WR_CNT;
              end else if (fitsEntry) begin
                logWen_q    <= 1'b1;
                logAddr_q   <= logPtr_q;
                logDin1_q   <= bus.cf_src;
                logDin2_q   <= bus.cf_dst;
                logPtr_q    <= logPtr_q + TWO;
                lastSrc_q   <= bus.cf_src;
                lastDst_q   <= bus.cf_dst;
                lastValid_q <= 1'b1;
                state_q     <= WR_PAIR;
              end else begin
                pendValid_q <= 1'b1;
                flushReq_q  <= 1'b1;
                state_q     <= FLUSH;
              end
            end
          end else if (bus.flush_now) begin
            cfReady_q   <= 1'b0;
            pendValid_q <= 1'b0;
            if (fitsEntry && cntPending) begin
              logWen_q  <= 1'b1;
              logAddr_q <= logPtr_q;
              logDin1_q <= 16'hFFFF;
              logDin2_q <= rptCnt_q;
              logPtr_q  <= logPtr_q + TWO;
              rptCnt_q  <= '0;
              state_q   <= WR_CNT;
            end else begin
              flushReq_q <= 1'b1;
              state_q    <= FLUSH;
            end
          end
        end
        // Count already issued; the pointer now reflects it when deciding whether the pair fits.
        WR_CNT: begin
          if (pendValid_q && fitsEntry) begin
            logWen_q    <= 1'b1;
            logAddr_q   <= logPtr_q;
            logDin1_q   <= pendSrc_q;
            logDin2_q   <= pendDst_q;
            logPtr_q    <= logPtr_q + TWO;
            lastSrc_q   <= pendSrc_q;
            lastDst_q   <= pendDst_q;
            lastValid_q <= 1'b1;
            pendValid_q <= 1'b0;
            state_q     <= WR_PAIR;
          end else begin
            flushReq_q <= 1'b1;
            state_q    <= FLUSH;
          end
        end
        WR_PAIR: begin
          cfReady_q <= 1'b1;
          state_q   <= IDLE;
        end
        FLUSH: begin
          if (bus.flush_ack) begin
            flushReq_q <= 1'b0;
            rptCnt_q   <= '0;
            if (pendValid_q) begin
              logWen_q    <= 1'b1;
              logAddr_q   <= '0;
              logDin1_q   <= pendSrc_q;
              logDin2_q   <= pendDst_q;
              logPtr_q    <= TWO;
              lastSrc_q   <= pendSrc_q;
              lastDst_q   <= pendDst_q;
              lastValid_q <= 1'b1;
              pendValid_q <= 1'b0;
              state_q     <= WR_PAIR;
            end else begin
              logPtr_q    <= '0;
              lastValid_q <= 1'b0;
              cfReady_q   <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cf_ready  = cfReady_q;
  assign bus.flush_req = flushReq_q;
  assign bus.log_wen   = logWen_q;
  assign bus.log_addr  = logAddr_q;
  assign bus.log_din1  = logDin1_q;
  assign bus.log_din2  = logDin2_q;
  assign bus.log_ptr   = logPtr_q;
endmodule

// File: tb/tb_cflog_writer.sv
// Bench for cflog_writer with an 8-word log: vector table, hand-written flush/reset sequences,
// and a randomized run scored against an event-level model of the log contents.
module tb_cflog_writer;
  localparam int LOG_SIZE = 16;
  localparam int ADDR_MSB = 3;
  localparam int WORDS    = LOG_SIZE / 2;

  logic mclk = 1'b0;
  logic puc_rst;
  logic ackAuto, ackMan, autoAck;
  int   checks = 0;
  int   errors = 0;

  always #5 mclk = ~mclk;

  cflog_writer_if #(.ADDR_MSB(ADDR_MSB)) bus ();
  assign bus.flush_ack = ackAuto | ackMan;

  cflog_writer #(.LOG_SIZE(LOG_SIZE), .ADDR_MSB(ADDR_MSB)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .bus(bus)
  );

  typedef struct {
    logic [ADDR_MSB:0] addr;
    logic [15:0]       d1;
    logic [15:0]       d2;
  } wr_t;

  typedef struct {
    bit rst; bit en; logic [15:0] src; logic [15:0] dst; bit rdy1;
    bit wen1; int addr1; logic [15:0] a1; logic [15:0] b1;
    bit wen2; int addr2; logic [15:0] a2; logic [15:0] b2;
    int ptr;
  } vec_t;

  wr_t  expQ[$];
  wr_t  actQ[$];
  vec_t vecs[10];
  int   mPtr, mRpt, mFlushes, actFlushes;
  bit   mLastValid, monOn, prevReq;
  logic [15:0] mLastSrc, mLastDst;

  // Event-level model: tracks what the log should contain, not how many cycles it takes.
  function automatic void modelReset();
    mPtr = 0; mRpt = 0; mLastValid = 0; mLastSrc = '0; mLastDst = '0;
  endfunction

  function automatic void modelWrite(int a, logic [15:0] d1, logic [15:0] d2);
    wr_t w;
    w.addr = (ADDR_MSB + 1)'(a); w.d1 = d1; w.d2 = d2;
    expQ.push_back(w);
  endfunction

  function automatic void modelFlush();
    mFlushes++; mPtr = 0; mRpt = 0; mLastValid = 0;
  endfunction

  function automatic void modelCount();
    modelWrite(mPtr, 16'hFFFF, 16'(mRpt)); mPtr += 2; mRpt = 0;
  endfunction

  function automatic void modelPair(logic [15:0] s, logic [15:0] d);
    modelWrite(mPtr, s, d); mPtr += 2; mLastSrc = s; mLastDst = d; mLastValid = 1;
  endfunction

  function automatic void modelEvent(bit en, logic [15:0] s, logic [15:0] d);
    int free;
    if (!en) return;
    if (mLastValid && s == mLastSrc && d == mLastDst && mRpt != 65535) begin
      mRpt++;
      return;
    end
    free = WORDS - mPtr;
    if (free >= ((mRpt != 0) ? 4 : 2)) begin
      if (mRpt != 0) modelCount();
      modelPair(s, d);
    end else if (mRpt != 0 && free >= 2) begin
      modelCount(); modelFlush(); modelPair(s, d);
    end else begin
      modelFlush(); modelPair(s, d);
    end
  endfunction

  function automatic void modelFlushNow();
    if (mRpt != 0 && WORDS - mPtr >= 2) modelCount();
    modelFlush();
  endfunction

  always @(negedge mclk) begin
    if (monOn) begin
      if (bus.log_wen) begin
        wr_t w;
        w.addr = bus.log_addr; w.d1 = bus.log_din1; w.d2 = bus.log_din2;
        actQ.push_back(w);
      end
      if (bus.flush_req && !prevReq) actFlushes++;
    end
    prevReq = bus.flush_req;
  end

  initial begin
    ackAuto = 1'b0;
    forever begin
      @(negedge mclk);
      if (autoAck && bus.flush_req) begin
        repeat ($urandom_range(0, 3)) @(negedge mclk);
        ackAuto = 1'b1;
        @(negedge mclk);
        ackAuto = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge mclk); #1;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (bus.cf_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("[TB] FAIL waitIdle cf_ready actual=0 required=1 (timeout)");
    end
  endtask

  task automatic applyStimulus(input bit en, input logic [15:0] s, input logic [15:0] d);
    waitIdle();
    bus.enable = en; bus.cf_src = s; bus.cf_dst = d; bus.cf_valid = 1'b1;
    @(posedge mclk); #1;
    bus.cf_valid = 1'b0;
  endtask

  task automatic applyFlushNow();
    waitIdle();
    bus.flush_now = 1'b1;
    @(posedge mclk); #1;
    bus.flush_now = 1'b0;
  endtask

  task automatic pulseAck();
    @(negedge mclk); ackMan = 1'b1;
    @(posedge mclk); #1;
    ackMan = 1'b0;
  endtask

  task automatic doReset();
    puc_rst = 1'b1;
    repeat (2) @(posedge mclk);
    #1 puc_rst = 1'b0;
    modelReset();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " cf_ready"},  64'(bus.cf_ready),  64'd1);
    checkOutput({tag, " flush_req"}, 64'(bus.flush_req), 64'd0);
    checkOutput({tag, " log_wen"},   64'(bus.log_wen),   64'd0);
    checkOutput({tag, " log_addr"},  64'(bus.log_addr),  64'd0);
    checkOutput({tag, " log_din1"},  64'(bus.log_din1),  64'd0);
    checkOutput({tag, " log_din2"},  64'(bus.log_din2),  64'd0);
    checkOutput({tag, " log_ptr"},   64'(bus.log_ptr),   64'd0);
  endtask

  task automatic checkQuiet(input string tag);
    int seen;
    seen = 0;
    repeat (4) begin
      cycle();
      if (bus.log_wen || bus.flush_req) seen++;
    end
    checkOutput({tag, " quiet"}, 64'(seen), 64'd0);
  endtask

  task automatic checkWrite(input string tag, input int a, input logic [15:0] d1, input logic [15:0] d2);
    checkOutput({tag, " log_wen"},  64'(bus.log_wen),  64'd1);
    checkOutput({tag, " log_addr"}, 64'(bus.log_addr), 64'(a));
    checkOutput({tag, " log_din1"}, 64'(bus.log_din1), 64'(d1));
    checkOutput({tag, " log_din2"}, 64'(bus.log_din2), 64'(d2));
  endtask

  initial begin
    logic [15:0] s, d, lastS, lastD;
    bit en;
    puc_rst = 1'b1; ackMan = 1'b0; autoAck = 1'b0; monOn = 1'b0; prevReq = 1'b0;
    bus.enable = 1'b1; bus.cf_valid = 1'b0; bus.cf_src = '0; bus.cf_dst = '0; bus.flush_now = 1'b0;
    mFlushes = 0; actFlushes = 0;

    doReset();
    checkResetOutputs("reset");

    vecs[0] = '{1, 1, 16'h1000, 16'h2000, 0, 1, 0, 16'h1000, 16'h2000, 0, 0, 16'h0, 16'h0, 2};
    vecs[1] = '{0, 1, 16'h1004, 16'h3000, 0, 1, 2, 16'h1004, 16'h3000, 0, 0, 16'h0, 16'h0, 4};
    vecs[2] = '{1, 1, 16'h000A, 16'h000B, 0, 1, 0, 16'h000A, 16'h000B, 0, 0, 16'h0, 16'h0, 2};
    for (int i = 3; i < 7; i++)
      vecs[i] = '{0, 1, 16'h000A, 16'h000B, 1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 2};
    vecs[7] = '{0, 1, 16'h000C, 16'h000D, 0, 1, 2, 16'hFFFF, 16'h0004, 1, 4, 16'h000C, 16'h000D, 6};
    vecs[8] = '{0, 1, 16'h000E, 16'h000F, 0, 1, 6, 16'h000E, 16'h000F, 0, 0, 16'h0, 16'h0, 8};
    vecs[9] = '{0, 0, 16'h0001, 16'h0002, 1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 8};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].en, vecs[i].src, vecs[i].dst);
      checkOutput($sformatf("vec%0d cf_ready", i), 64'(bus.cf_ready), 64'(vecs[i].rdy1));
      if (vecs[i].wen1) checkWrite($sformatf("vec%0d w1", i), vecs[i].addr1, vecs[i].a1, vecs[i].b1);
      else checkOutput($sformatf("vec%0d w1 log_wen", i), 64'(bus.log_wen), 64'd0);
      cycle();
      if (vecs[i].wen2) checkWrite($sformatf("vec%0d w2", i), vecs[i].addr2, vecs[i].a2, vecs[i].b2);
      else checkOutput($sformatf("vec%0d w2 log_wen", i), 64'(bus.log_wen), 64'd0);
      waitIdle();
      checkOutput($sformatf("vec%0d log_ptr", i), 64'(bus.log_ptr), 64'(vecs[i].ptr));
    end

    // Full log: the fifth distinct pair must wait for the flush handshake.
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, 16'(i), 16'(i));
    applyStimulus(1, 16'h0005, 16'h0006);
    checkOutput("full flush_req", 64'(bus.flush_req), 64'd1);
    checkOutput("full log_wen", 64'(bus.log_wen), 64'd0);
    repeat (3) cycle();
    checkOutput("full flush_req held", 64'(bus.flush_req), 64'd1);
    pulseAck();
    checkWrite("full afterAck", 0, 16'h0005, 16'h0006);
    checkOutput("full flush_req drop", 64'(bus.flush_req), 64'd0);
    waitIdle();
    checkOutput("full log_ptr", 64'(bus.log_ptr), 64'd2);

    doReset();
    for (int i = 1; i <= 3; i++) applyStimulus(1, 16'(i), 16'(i));
    applyStimulus(1, 16'h0003, 16'h0003);
    applyStimulus(1, 16'h0003, 16'h0003);
    applyStimulus(1, 16'h0007, 16'h0008);
    checkWrite("cntFlush cnt", 6, 16'hFFFF, 16'h0002);
    cycle();
    checkOutput("cntFlush flush_req", 64'(bus.flush_req), 64'd1);
    checkOutput("cntFlush log_ptr", 64'(bus.log_ptr), 64'd8);
    pulseAck();
    checkWrite("cntFlush pair", 0, 16'h0007, 16'h0008);

    doReset();
    applyStimulus(1, 16'h000A, 16'h000B);
    waitIdle();
    pulseAck();
    checkOutput("strayAck log_ptr", 64'(bus.log_ptr), 64'd2);
    checkOutput("strayAck flush_req", 64'(bus.flush_req), 64'd0);
    repeat (3) applyStimulus(1, 16'h000A, 16'h000B);
    applyFlushNow();
    checkWrite("flushNow cnt", 2, 16'hFFFF, 16'h0003);
    cycle();
    checkOutput("flushNow flush_req", 64'(bus.flush_req), 64'd1);
    pulseAck();
    checkOutput("flushNow flush_req drop", 64'(bus.flush_req), 64'd0);
    checkOutput("flushNow log_ptr", 64'(bus.log_ptr), 64'd0);
    checkOutput("flushNow cf_ready", 64'(bus.cf_ready), 64'd1);
    applyStimulus(1, 16'h000A, 16'h000B);
    checkWrite("flushNow samePair", 0, 16'h000A, 16'h000B);

    doReset();
    applyStimulus(1, 16'h0001, 16'h0002);
    applyFlushNow();
    checkOutput("rstFlush flush_req", 64'(bus.flush_req), 64'd1);
    puc_rst = 1'b1; cycle(); puc_rst = 1'b0;
    checkResetOutputs("rstFlush");
    checkQuiet("rstFlush");

    doReset();
    applyStimulus(1, 16'h0001, 16'h0002);
    applyStimulus(1, 16'h0001, 16'h0002);
    applyFlushNow();
    checkWrite("rstCnt cnt", 2, 16'hFFFF, 16'h0001);
    puc_rst = 1'b1; cycle(); puc_rst = 1'b0;
    checkResetOutputs("rstCnt");
    checkQuiet("rstCnt");

    doReset();
    expQ.delete(); actQ.delete();
    mFlushes = 0; actFlushes = 0;
    monOn = 1'b1; autoAck = 1'b1;
    lastS = 16'h0100; lastD = 16'h0200;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        applyFlushNow();
        modelFlushNow();
      end else begin
        en = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 2) == 0) begin
          s = lastS; d = lastD;
        end else begin
          s = 16'h0100 + 16'($urandom_range(0, 3));
          d = 16'h0200 + 16'($urandom_range(0, 1));
        end
        lastS = s; lastD = d;
        applyStimulus(en, s, d);
        modelEvent(en, s, d);
      end
    end
    waitIdle();
    repeat (2) cycle();
    monOn = 1'b0; autoAck = 1'b0;
    checkOutput("rnd writeCount", 64'(actQ.size()), 64'(expQ.size()));
    for (int i = 0; i < actQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("rnd write%0d", i),
                  64'({actQ[i].addr, actQ[i].d1, actQ[i].d2}),
                  64'({expQ[i].addr, expQ[i].d1, expQ[i].d2}));
    checkOutput("rnd flushes", 64'(actFlushes), 64'(mFlushes));
    checkOutput("rnd log_ptr", 64'(bus.log_ptr), 64'(mPtr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
